// File: rtl/config_chain_pkg.sv
// Shared types and sizing helpers for the configuration-chain loader.
package config_chain_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_WORD = 2'd1,
        SHIFT     = 2'd2,
        DONE      = 2'd3
    } loader_state_t;

    function automatic int unsigned num_words(input int unsigned chain_len,
                                              input int unsigned word_w);
        return (chain_len + word_w - 1) / word_w;
    endfunction

    // Bits carried by the final word of a load (1..word_w).
    function automatic int unsigned last_word_bits(input int unsigned chain_len,
                                                   input int unsigned word_w);
        return chain_len - (num_words(chain_len, word_w) - 1) * word_w;
    endfunction

endpackage

// File: rtl/config_readback_deser.sv
// Collects bits returned from the chain tail into LSB-first readback words,
// flushing a short final word zero-padded.
module config_readback_deser
    import config_chain_pkg::*;
#(
    parameter int unsigned WORD_WIDTH   = 32,
    parameter int unsigned CHAIN_LENGTH = 1024
) (
    input  logic                  clock,
    input  logic                  config_nreset,
    input  logic                  i_clear,
    input  logic                  i_sample,
    input  logic                  i_bit,
    output logic [WORD_WIDTH-1:0] o_data,
    output logic                  o_valid
);
    localparam int unsigned NUM_WORDS = num_words(CHAIN_LENGTH, WORD_WIDTH);
    localparam int unsigned LAST_BITS = last_word_bits(CHAIN_LENGTH, WORD_WIDTH);
    localparam int unsigned BIT_W     = (WORD_WIDTH > 1) ? $clog2(WORD_WIDTH) : 1;
    localparam int unsigned WRD_W     = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;

    logic [WORD_WIDTH-1:0] r_acc;
    logic [WORD_WIDTH-1:0] r_data;
    logic [BIT_W-1:0]      r_bitcnt;
    logic [WRD_W-1:0]      r_wordcnt;
    logic                  r_valid;
    logic [WORD_WIDTH-1:0] w_acc_next;
    logic                  w_final;
    logic                  w_full;

    always_comb begin
        w_acc_next           = r_acc;
        w_acc_next[r_bitcnt] = i_bit;
    end

    assign w_final = (r_wordcnt == WRD_W'(NUM_WORDS - 1)) &&
                     (r_bitcnt  == BIT_W'(LAST_BITS - 1));
    assign w_full  = (r_bitcnt == BIT_W'(WORD_WIDTH - 1));

    always_ff @(posedge clock or negedge config_nreset) begin
        if (!config_nreset) begin
            r_acc     <= '0;
            r_data    <= '0;
            r_bitcnt  <= '0;
            r_wordcnt <= '0;
            r_valid   <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            if (i_clear) begin
                r_acc     <= '0;
                r_bitcnt  <= '0;
                r_wordcnt <= '0;
            end else if (i_sample) begin
                if (w_full || w_final) begin
                    r_data    <= w_acc_next;
                    r_valid   <= 1'b1;
                    r_acc     <= '0;
                    r_bitcnt  <= '0;
                    r_wordcnt <= w_final ? '0 : r_wordcnt + WRD_W'(1);
                end else begin
                    r_acc    <= w_acc_next;
                    r_bitcnt <= r_bitcnt + BIT_W'(1);
                end
            end
        end
    end

    assign o_data  = r_data;
    assign o_valid = r_valid;

endmodule

// File: rtl/config_chain_loader.sv
// Serialises bitstream words into the tile configuration chain while
// returning the previous chain contents as readback words.
module config_chain_loader
    import config_chain_pkg::*;
#(
    parameter int unsigned WORD_WIDTH   = 32,
    parameter int unsigned CHAIN_LENGTH = 1024,
    parameter int unsigned COUNT_WIDTH  = $clog2(CHAIN_LENGTH + 1)
) (
    input  logic                  clock,
    input  logic                  config_nreset,
    input  logic                  start,
    input  logic [WORD_WIDTH-1:0] word_data,
    input  logic                  word_valid,
    output logic                  word_ready,
    output logic                  chain_config_out,
    output logic                  chain_config_enable,
    input  logic                  chain_config_return,
    output logic [WORD_WIDTH-1:0] readback_data,
    output logic                  readback_valid,
    output logic                  busy,
    output logic                  done
);
    localparam int unsigned WCNT_W = $clog2(WORD_WIDTH + 1);

    loader_state_t         r_state;
    logic [WORD_WIDTH-1:0] r_shreg;
    logic [COUNT_WIDTH-1:0] r_remaining;
    logic [WCNT_W-1:0]     r_wcnt;
    logic                  r_ready;
    logic                  r_out;
    logic                  r_enable;
    logic                  r_busy;
    logic                  r_done;
    logic [WCNT_W-1:0]     w_word_bits;
    logic                  w_clear;

    // Bits to shift for the word being accepted: a full word or the tail.
    assign w_word_bits = (32'(r_remaining) >= WORD_WIDTH) ? WCNT_W'(WORD_WIDTH)
                                                          : WCNT_W'(r_remaining);
    assign w_clear     = (r_state == IDLE) && start;

    always_ff @(posedge clock or negedge config_nreset) begin
        if (!config_nreset) begin
            r_state     <= IDLE;
            r_shreg     <= '0;
            r_remaining <= '0;
            r_wcnt      <= '0;
            r_ready     <= 1'b0;
            r_out       <= 1'b0;
            r_enable    <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    r_remaining <= COUNT_WIDTH'(CHAIN_LENGTH);
                    if (start) begin
                        r_state <= WAIT_WORD;
                        r_ready <= 1'b1;
                        r_busy  <= 1'b1;
                    end
                end
                WAIT_WORD: begin
                    if (word_valid) begin
                        r_shreg  <= word_data;
                        r_out    <= word_data[0];
                        r_wcnt   <= w_word_bits;
                        r_ready  <= 1'b0;
                        r_enable <= 1'b1;
                        r_state  <= SHIFT;
                    end
                end
                SHIFT: begin
                    r_shreg     <= r_shreg >> 1;
                    r_out       <= r_shreg[1];
                    r_remaining <= r_remaining - COUNT_WIDTH'(1);
                    r_wcnt      <= r_wcnt - WCNT_W'(1);
                    if (r_wcnt == WCNT_W'(1)) begin
                        r_enable <= 1'b0;
                        r_out    <= 1'b0;
                        if (r_remaining == COUNT_WIDTH'(1)) begin
                            r_state <= DONE;
                            r_done  <= 1'b1;
                        end else begin
                            r_state <= WAIT_WORD;
                            r_ready <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    config_readback_deser #(
        .WORD_WIDTH   (WORD_WIDTH),
        .CHAIN_LENGTH (CHAIN_LENGTH)
    ) u_deser (
        .clock         (clock),
        .config_nreset (config_nreset),
        .i_clear       (w_clear),
        .i_sample      (r_enable),
        .i_bit         (chain_config_return),
        .o_data        (readback_data),
        .o_valid       (readback_valid)
    );

    assign word_ready          = r_ready;
    assign chain_config_out    = r_out;
    assign chain_config_enable = r_enable;
    assign busy                = r_busy;
    assign done                = r_done;

endmodule

// File: tb/tb_config_chain_loader.sv
// Directed bench: loader driving a 20-bit behavioural chain, readback
// checked against a scoreboard of the chain contents before each load.
module tb_config_chain_loader;
    localparam int unsigned WW = 8;
    localparam int unsigned CL = 20;

    logic          clock = 1'b0;
    logic          config_nreset;
    logic          start;
    logic [WW-1:0] word_data;
    logic          word_valid;
    logic          word_ready;
    logic          chain_config_out;
    logic          chain_config_enable;
    logic          chain_config_return;
    logic [WW-1:0] readback_data;
    logic          readback_valid;
    logic          busy;
    logic          done;

    config_chain_loader #(.WORD_WIDTH(WW), .CHAIN_LENGTH(CL)) dut (
        .clock               (clock),
        .config_nreset       (config_nreset),
        .start               (start),
        .word_data           (word_data),
        .word_valid          (word_valid),
        .word_ready          (word_ready),
        .chain_config_out    (chain_config_out),
        .chain_config_enable (chain_config_enable),
        .chain_config_return (chain_config_return),
        .readback_data       (readback_data),
        .readback_valid      (readback_valid),
        .busy                (busy),
        .done                (done)
    );

    always #5 clock = ~clock;

    int n_cmp = 0;
    int n_err = 0;
    bit mon_on = 1'b0;

    // Behavioural chain: bit 19 is the first tile's input, bit 0 the tail.
    logic [CL-1:0] chain = '0;
    assign chain_config_return = chain[0];
    always @(posedge clock)
        if (mon_on && chain_config_enable === 1'b1)
            chain <= {chain_config_out, chain[CL-1:1]};

    logic [WW-1:0] sb[$];
    logic [CL-1:0] exp_chain = '0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    int          en_total = 0;
    int          burst_total = 0;
    int          done_total = 0;
    logic        prev_en = 1'b0;
    logic [31:0] out_hist = '0;

    always @(negedge clock) begin
        if (mon_on && config_nreset) begin
            if (chain_config_enable) begin
                en_total++;
                out_hist = {chain_config_out, out_hist[31:1]};
                if (!prev_en) burst_total++;
            end
            prev_en = chain_config_enable;
            if (done) done_total++;
            if (readback_valid) begin
                if (sb.size() == 0) chk("readback_unexpected", 32'(sb.size()), 32'd1);
                else chk("readback", 32'(readback_data), 32'(sb.pop_front()));
            end
        end else begin
            prev_en = 1'b0;
        end
    end

    task automatic wait_ready(input string tag);
        int n = 0;
        while (!word_ready && n < 100) begin
            @(negedge clock);
            n++;
        end
        chk(tag, 32'(word_ready), 32'd1);
    endtask

    task automatic run_load(input logic [WW-1:0] w0, input logic [WW-1:0] w1,
                            input logic [WW-1:0] w2, input int stall, input bit poke_start);
        logic [WW-1:0] w[3];
        logic [CL-1:0] snap;
        int e0, b0, d0, n;
        w[0] = w0; w[1] = w1; w[2] = w2;
        sb.push_back(exp_chain[7:0]);
        sb.push_back(exp_chain[15:8]);
        sb.push_back({4'b0, exp_chain[19:16]});
        e0 = en_total; b0 = burst_total; d0 = done_total;
        @(negedge clock); start = 1'b1;
        @(negedge clock); start = 1'b0;
        chk("busy_after_start", 32'(busy), 32'd1);
        word_data = w[0]; word_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            if (i == 2 && stall > 0) begin
                word_valid = 1'b0;
                wait_ready("stall_ready");
                snap = chain;
                repeat (stall) begin
                    @(negedge clock);
                    chk("stall_enable", 32'(chain_config_enable), 32'd0);
                end
                chk("stall_chain", 32'(chain), 32'(snap));
                word_data = w[2]; word_valid = 1'b1;
            end
            wait_ready("word_ready");
            @(negedge clock);
            if (i < 2) word_data = w[i+1];
            else word_valid = 1'b0;
            if (poke_start && i == 0) begin
                start = 1'b1;
                @(negedge clock);
                start = 1'b0;
            end
        end
        n = 0;
        while (done_total == d0 && n < 100) begin
            @(negedge clock);
            n++;
        end
        repeat (3) @(negedge clock);
        exp_chain = {w[2][3:0], w[1], w[0]};
        chk("done_pulses", 32'(done_total - d0), 32'd1);
        chk("enable_cycles", 32'(en_total - e0), 32'd20);
        chk("enable_bursts", 32'(burst_total - b0), 32'd3);
        chk("readback_count_left", 32'(sb.size()), 32'd0);
        chk("out_stream", 32'(out_hist[31:12]), 32'(exp_chain));
        chk("chain_contents", 32'(chain), 32'(exp_chain));
        chk("busy_after_done", 32'(busy), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int k, n;
        config_nreset = 1'b1; start = 1'b0; word_data = '0; word_valid = 1'b0;

        // Reset asserted mid-cycle
        repeat (2) @(posedge clock);
        #3 config_nreset = 1'b0;
        #1;
        chk("rst_enable", 32'(chain_config_enable), 32'd0);
        chk("rst_out", 32'(chain_config_out), 32'd0);
        chk("rst_ready", 32'(word_ready), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_rb_valid", 32'(readback_valid), 32'd0);
        chk("rst_rb_data", 32'(readback_data), 32'd0);
        repeat (2) @(negedge clock);
        config_nreset = 1'b1;
        repeat (3) @(negedge clock);
        chk("post_rst_outputs",
            32'({chain_config_enable, chain_config_out, word_ready, busy, done,
                 readback_valid, readback_data}), 32'd0);
        mon_on = 1'b1;

        // First load into an all-zero chain
        run_load(8'hA5, 8'h3C, 8'h0F, 0, 1'b0);
        chk("first_out_bits", 32'(out_hist[19:12]), 32'hA5);

        // Second load, with start poked during SHIFT
        run_load(8'hFF, 8'hFF, 8'hFF, 0, 1'b1);
        chk("chain_all_ones", 32'(chain), 32'hFFFFF);

        // Stall before word 2
        run_load(8'h5A, 8'hC3, 8'h06, 5, 1'b0);

        // Reset after five enabled cycles
        @(negedge clock); start = 1'b1;
        @(negedge clock); start = 1'b0;
        word_data = 8'h11; word_valid = 1'b1;
        k = 0; n = 0;
        while (k < 5 && n < 100) begin
            @(negedge clock);
            n++;
            if (chain_config_enable) k++;
        end
        chk("midreset_enables_seen", 32'(k), 32'd5);
        @(posedge clock);
        #2 config_nreset = 1'b0;
        #1;
        chk("midreset_enable_drop", 32'(chain_config_enable), 32'd0);
        chk("midreset_busy", 32'(busy), 32'd0);
        chk("midreset_ready", 32'(word_ready), 32'd0);
        word_valid = 1'b0;
        exp_chain = {5'b10001, exp_chain[CL-1:5]};
        @(negedge clock); config_nreset = 1'b1;
        @(negedge clock);
        chk("midreset_idle_busy", 32'(busy), 32'd0);
        chk("midreset_idle_ready", 32'(word_ready), 32'd0);
        chk("midreset_partial_chain", 32'(chain), 32'(exp_chain));
        run_load(8'h11, 8'h22, 8'h03, 0, 1'b0);
        chk("final_chain", 32'(chain), 32'h32211);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
